// File: rtl/udp_rx_parser.sv
// GMII-style receive parser: preamble/SFD, Ethernet II, IPv4, UDP header checks,
// then streams the UDP payload of datagrams addressed to this node.
module udp_rx_parser #(
  parameter logic [47:0] self_mac    = 48'h0023543C471B,
  parameter logic [31:0] self_ip     = 32'h0A000021,
  parameter logic [15:0] udp_port    = 16'd5000,
  parameter logic [10:0] max_payload = 11'd1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_data,
  input  logic        i_data_vl,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_err,
  output logic [47:0] o_src_mac,
  output logic [31:0] o_src_ip,
  output logic [15:0] o_src_port,
  output logic [15:0] o_pkt_cntr,
  output logic [15:0] o_drop_cntr
);

  typedef enum logic [2:0] {SKIP, IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD} state_t;

  state_t       state_reg, state_next;
  logic [10:0]  cnt_reg, cnt_next;
  logic [151:0] hist_reg;
  logic [159:0] win;
  logic [15:0]  csum_reg, csum_next;
  logic [16:0]  csum_sum;
  logic [10:0]  len_reg;
  logic [47:0]  mac_cap_reg;
  logic [31:0]  ip_cap_reg;
  logic [15:0]  port_cap_reg;
  logic [15:0]  udp_len;
  logic         eth_ok, ip_fmt_ok, ip_dst_ok, udp_len_ok, last;
  logic         emit, abort, drop, accept, accept_zero, cap_eth, cap_ip, load_len;

  // Window of the last 20 received bytes, newest byte in the low 8 bits.
  assign win = {hist_reg, i_data};

  always_comb begin
    csum_sum   = {1'b0, (cnt_reg == 11'd1) ? 16'h0000 : csum_reg} + {1'b0, hist_reg[7:0], i_data};
    csum_next  = csum_sum[15:0] + {15'd0, csum_sum[16]};
    eth_ok     = ((win[111:64] == self_mac) || (win[111:64] == 48'hFFFFFFFFFFFF)) &&
                 (win[15:0] == 16'h0800);
    ip_fmt_ok  = (win[159:152] == 8'h45) && (win[143:128] >= 16'd28) && !win[109] &&
                 (win[108:96] == 13'd0) && (win[87:80] == 8'd17);
    ip_dst_ok  = (win[31:0] == self_ip);
    udp_len    = win[31:16];
    udp_len_ok = (udp_len >= 16'd8) && (udp_len <= ({5'd0, max_payload} + 16'd8));
    last       = (cnt_reg == len_reg - 11'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SKIP;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    emit        = 1'b0;
    abort       = 1'b0;
    drop        = 1'b0;
    accept      = 1'b0;
    accept_zero = 1'b0;
    cap_eth     = 1'b0;
    cap_ip      = 1'b0;
    load_len    = 1'b0;
    case (state_reg)
      SKIP: if (!i_data_vl) state_next = IDLE;
      IDLE: if (i_data_vl) begin
        if (i_data == 8'h55) begin
          state_next = PREAMBLE;
          cnt_next   = 11'd1;
        end else begin
          state_next = SKIP;
        end
      end
      PREAMBLE: begin
        if (!i_data_vl) state_next = IDLE;
        else if (i_data == 8'hD5) begin
          state_next = ETH_HDR;
          cnt_next   = '0;
        end else if (i_data == 8'h55 && cnt_reg < 11'd7) cnt_next = cnt_reg + 11'd1;
        else state_next = SKIP;
      end
      ETH_HDR, IP_HDR, UDP_HDR: begin
        if (!i_data_vl) begin
          drop       = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 11'd1;
          if (state_reg == ETH_HDR && cnt_reg == 11'd13) begin
            cnt_next   = '0;
            state_next = eth_ok ? IP_HDR : SKIP;
            cap_eth    = eth_ok;
          end
          // Format errors outrank the silent address mismatch; checksum is judged last.
          if (state_reg == IP_HDR && cnt_reg == 11'd19) begin
            cnt_next   = '0;
            state_next = SKIP;
            if (!ip_fmt_ok) drop = 1'b1;
            else if (ip_dst_ok) begin
              if (csum_next != 16'hFFFF) drop = 1'b1;
              else begin
                state_next = UDP_HDR;
                cap_ip     = 1'b1;
              end
            end
          end
          if (state_reg == UDP_HDR && cnt_reg == 11'd7) begin
            cnt_next   = '0;
            state_next = SKIP;
            if (win[47:32] == udp_port) begin
              if (!udp_len_ok) drop = 1'b1;
              else if (udp_len == 16'd8) begin
                accept      = 1'b1;
                accept_zero = 1'b1;
              end else begin
                state_next = PAYLOAD;
                load_len   = 1'b1;
              end
            end
          end
        end
      end
      PAYLOAD: begin
        if (!i_data_vl) begin
          abort      = 1'b1;
          drop       = 1'b1;
          state_next = IDLE;
        end else begin
          emit = 1'b1;
          if (last) begin
            accept     = 1'b1;
            state_next = SKIP;
          end else begin
            cnt_next = cnt_reg + 11'd1;
          end
        end
      end
      default: state_next = SKIP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg     <= '0;
      csum_reg     <= '0;
      len_reg      <= '0;
      mac_cap_reg  <= '0;
      ip_cap_reg   <= '0;
      port_cap_reg <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_err        <= 1'b0;
      o_src_mac    <= '0;
      o_src_ip     <= '0;
      o_src_port   <= '0;
      o_pkt_cntr   <= '0;
      o_drop_cntr  <= '0;
    end else begin
      if (i_data_vl) hist_reg <= win[151:0];
      if (state_reg == IP_HDR && i_data_vl && cnt_reg[0]) csum_reg <= csum_next;
      if (cap_eth) mac_cap_reg <= win[63:16];
      if (cap_ip) ip_cap_reg <= win[63:32];
      if (load_len) begin
        len_reg      <= udp_len[10:0] - 11'd8;
        port_cap_reg <= win[63:48];
      end
      o_data  <= emit ? i_data : 8'h00;
      o_valid <= emit;
      o_sop   <= emit && (cnt_reg == 11'd0);
      o_eop   <= (emit && last) || abort;
      o_err   <= abort;
      if (accept) begin
        o_src_mac  <= mac_cap_reg;
        o_src_ip   <= ip_cap_reg;
        o_src_port <= accept_zero ? win[63:48] : port_cap_reg;
        o_pkt_cntr <= o_pkt_cntr + 16'd1;
      end
      if (drop) o_drop_cntr <= o_drop_cntr + 16'd1;
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Frames are described by header fields, serialised to bytes, and the expected
// outcome is derived from those fields by a rule-level model.
module tb_udp_rx_parser;
  localparam logic [47:0] SELF_MAC = 48'h0023543C471B;
  localparam logic [31:0] SELF_IP  = 32'h0A000021;
  localparam logic [15:0] UDP_PORT = 16'd5000;
  localparam int          MAX_PL   = 1472;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic i_data_vl = 1'b0;
  logic [7:0] o_data;
  logic o_valid, o_sop, o_eop, o_err;
  logic [47:0] o_src_mac;
  logic [31:0] o_src_ip;
  logic [15:0] o_src_port, o_pkt_cntr, o_drop_cntr;

  always #4 clk = ~clk;

  udp_rx_parser dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_data_vl(i_data_vl),
    .o_data(o_data), .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop), .o_err(o_err),
    .o_src_mac(o_src_mac), .o_src_ip(o_src_ip), .o_src_port(o_src_port),
    .o_pkt_cntr(o_pkt_cntr), .o_drop_cntr(o_drop_cntr)
  );

  // Output monitor: cumulative record, read by the stimulus block as deltas.
  logic [7:0] mon_d[$];
  logic       mon_s[$];
  logic       mon_e[$];
  int mon_err = 0, mon_abort = 0, mon_stray = 0;

  always @(negedge clk) begin
    if (o_valid) begin
      mon_d.push_back(o_data);
      mon_s.push_back(o_sop);
      mon_e.push_back(o_eop);
    end
    if (o_err) mon_err++;
    if (o_eop && o_err && !o_valid) mon_abort++;
    if (!o_valid && (o_sop || (o_eop && !o_err))) mon_stray++;
  end

  int checks = 0, errors = 0;

  logic [47:0] f_dst, f_src;
  logic [15:0] f_etype, f_totlen, f_sport, f_dport, f_ulen;
  logic [7:0]  f_verihl, f_ttl, f_proto;
  logic        f_mf, f_bad_csum;
  logic [12:0] f_frag;
  logic [31:0] f_sip, f_dip;
  int          f_npre, f_cut, f_rst_at;
  logic [7:0]  f_pl[$];
  logic [7:0]  tx[$];

  logic [7:0]  exp_d[$];
  int          exp_abort;
  logic [15:0] exp_pkt = 16'd0, exp_drop = 16'd0, exp_port = 16'd0;
  logic [47:0] exp_mac = 48'd0;
  logic [31:0] exp_ip = 32'd0;

  task automatic chk(input string tag, input string what, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s/%s got %0h want %0h", tag, what, got, want);
    end
  endtask

  task automatic set_good(input int n);
    f_dst = SELF_MAC; f_src = {16'($urandom()), $urandom()}; f_etype = 16'h0800;
    f_verihl = 8'h45; f_ttl = 8'd64; f_proto = 8'd17; f_mf = 1'b0; f_frag = 13'd0;
    f_totlen = 16'(28 + n); f_sip = $urandom(); f_dip = SELF_IP;
    f_sport = 16'($urandom()); f_dport = UDP_PORT; f_ulen = 16'(8 + n);
    f_bad_csum = 1'b0; f_npre = 7; f_cut = -1; f_rst_at = -1;
    f_pl.delete();
    for (int i = 0; i < n; i++) f_pl.push_back(8'($urandom()));
  endtask

  task automatic build();
    logic [7:0] ip[20];
    int sum, nsend;
    logic [15:0] cs;
    tx.delete();
    repeat (f_npre) tx.push_back(8'h55);
    tx.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) tx.push_back(f_dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) tx.push_back(f_src[8*i +: 8]);
    tx.push_back(f_etype[15:8]); tx.push_back(f_etype[7:0]);
    ip[0] = f_verihl; ip[1] = 8'h00; ip[2] = f_totlen[15:8]; ip[3] = f_totlen[7:0];
    ip[4] = 8'h12; ip[5] = 8'h34; ip[6] = {2'b00, f_mf, f_frag[12:8]}; ip[7] = f_frag[7:0];
    ip[8] = f_ttl; ip[9] = f_proto; ip[10] = 8'h00; ip[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ip[12+i] = f_sip[8*(3-i) +: 8];
      ip[16+i] = f_dip[8*(3-i) +: 8];
    end
    sum = 0;
    for (int k = 0; k < 10; k++) sum += int'({ip[2*k], ip[2*k+1]});
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    cs = ~16'(sum);
    ip[10] = cs[15:8]; ip[11] = cs[7:0];
    if (f_bad_csum) ip[8] = ip[8] ^ 8'h01;
    for (int i = 0; i < 20; i++) tx.push_back(ip[i]);
    tx.push_back(f_sport[15:8]); tx.push_back(f_sport[7:0]);
    tx.push_back(f_dport[15:8]); tx.push_back(f_dport[7:0]);
    tx.push_back(f_ulen[15:8]);  tx.push_back(f_ulen[7:0]);
    tx.push_back(8'h00); tx.push_back(8'h00);
    nsend = (f_cut >= 0) ? f_cut : f_pl.size();
    for (int i = 0; i < nsend; i++) tx.push_back(f_pl[i]);
    if (f_cut < 0) begin
      while (tx.size() < f_npre + 1 + 60) tx.push_back(8'h00);
      repeat (4) tx.push_back(8'($urandom()));
    end
  endtask

  task automatic predict();
    int n;
    exp_d.delete();
    exp_abort = 0;
    if (f_rst_at >= 0) begin
      exp_pkt = 0; exp_drop = 0; exp_mac = 0; exp_ip = 0; exp_port = 0;
      return;
    end
    if (f_npre < 1 || f_npre > 7) return;
    if (!(f_dst == SELF_MAC || f_dst == 48'hFFFFFFFFFFFF) || f_etype != 16'h0800) return;
    if (f_verihl != 8'h45 || f_mf || f_frag != 0 || f_proto != 8'd17 || f_totlen < 16'd28) begin
      exp_drop++;
      return;
    end
    if (f_dip != SELF_IP) return;
    if (f_bad_csum) begin exp_drop++; return; end
    if (f_dport != UDP_PORT) return;
    if (int'(f_ulen) < 8 || int'(f_ulen) > MAX_PL + 8) begin exp_drop++; return; end
    n = int'(f_ulen) - 8;
    if (f_cut >= 0 && f_cut < n) begin
      for (int i = 0; i < f_cut; i++) exp_d.push_back(f_pl[i]);
      exp_abort = 1;
      exp_drop++;
      return;
    end
    for (int i = 0; i < n; i++) exp_d.push_back(f_pl[i]);
    exp_pkt++;
    exp_mac = f_src; exp_ip = f_sip; exp_port = f_sport;
  endtask

  task automatic run_frame(input string tag);
    int m_d, m_err, m_abort, m_stray, n_got, n_exp;
    predict();
    build();
    m_d = mon_d.size(); m_err = mon_err; m_abort = mon_abort; m_stray = mon_stray;
    for (int i = 0; i < tx.size(); i++) begin
      @(posedge clk); #1;
      rst = (i == f_rst_at);
      i_data_vl = 1'b1;
      i_data = tx[i];
    end
    @(posedge clk); #1;
    rst = 1'b0; i_data_vl = 1'b0; i_data = 8'h00;
    repeat (12) @(posedge clk);
    #1;
    n_got = mon_d.size() - m_d;
    n_exp = exp_d.size();
    chk(tag, "bytes", 64'(n_got), 64'(n_exp));
    for (int i = 0; i < n_got && i < n_exp; i++) begin
      chk(tag, $sformatf("data%0d", i), 64'(mon_d[m_d+i]), 64'(exp_d[i]));
      chk(tag, $sformatf("sop%0d", i), 64'(mon_s[m_d+i]), 64'(i == 0));
      chk(tag, $sformatf("eop%0d", i), 64'(mon_e[m_d+i]), 64'(exp_abort == 0 && i == n_exp - 1));
    end
    chk(tag, "abort", 64'(mon_abort - m_abort), 64'(exp_abort));
    chk(tag, "err", 64'(mon_err - m_err), 64'(exp_abort));
    chk(tag, "stray", 64'(mon_stray - m_stray), 64'd0);
    chk(tag, "pkt_cntr", 64'(o_pkt_cntr), 64'(exp_pkt));
    chk(tag, "drop_cntr", 64'(o_drop_cntr), 64'(exp_drop));
    chk(tag, "src_mac", 64'(o_src_mac), 64'(exp_mac));
    chk(tag, "src_ip", 64'(o_src_ip), 64'(exp_ip));
    chk(tag, "src_port", 64'(o_src_port), 64'(exp_port));
    $display("frame %s: sent %0d B, payload %0d/%0d B, pkt %0d drop %0d",
             tag, tx.size(), n_got, n_exp, o_pkt_cntr, o_drop_cntr);
  endtask

  initial begin
    int kind, n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "valid", 64'(o_valid), 64'd0);
    chk("reset", "eop", 64'(o_eop), 64'd0);
    chk("reset", "pkt_cntr", 64'(o_pkt_cntr), 64'd0);
    chk("reset", "drop_cntr", 64'(o_drop_cntr), 64'd0);
    chk("reset", "src_ip", 64'(o_src_ip), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    set_good(4);
    f_pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("good4");
    f_bad_csum = 1'b1;
    run_frame("bad_csum");
    set_good(1); f_dst = 48'hFFFFFFFFFFFF;
    run_frame("bcast1");
    set_good(10); f_cut = 2;
    run_frame("trunc2of10");
    set_good(6); f_rst_at = 20;
    run_frame("rst_mid");
    set_good(5);
    run_frame("after_rst");
    set_good(4); f_dport = 16'd5001;
    run_frame("wrong_port");
    set_good(4); f_etype = 16'h0806;
    run_frame("arp");
    set_good(4); f_mf = 1'b1;
    run_frame("mf");
    set_good(0);
    run_frame("len0");
    set_good(3); f_ulen = 16'd7;
    run_frame("ulen7");
    set_good(MAX_PL);
    run_frame("max_pl");
    set_good(4); f_ulen = 16'(MAX_PL + 9);
    run_frame("over_max");
    set_good(4); f_npre = 8;
    run_frame("pre8");
    set_good(4); f_npre = 1;
    run_frame("pre1");
    set_good(4); f_dip = 32'h0A000022;
    run_frame("wrong_ip");
    set_good(4); f_totlen = 16'd27;
    run_frame("totlen27");
    set_good(4); f_verihl = 8'h46;
    run_frame("ihl6");

    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(0, 40);
      set_good(n);
      kind = $urandom_range(0, 11);
      case (kind)
        0: f_dst = {16'h0200, $urandom()};
        1: f_etype = 16'h86DD;
        2: f_mf = 1'b1;
        3: f_frag = 13'($urandom_range(1, 8191));
        4: f_proto = 8'd6;
        5: f_bad_csum = 1'b1;
        6: f_dip = $urandom() | 32'h80000000;
        7: f_dport = 16'($urandom_range(0, 4999));
        8: f_dst = 48'hFFFFFFFFFFFF;
        9: if (n >= 1) f_cut = $urandom_range(0, n - 1);
        default: ;
      endcase
      run_frame($sformatf("rnd%0d_k%0d", r, kind));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
